// File: rtl/if_id_stage_if.sv
// if_id_stage_if: bundles the hazard-unit controls, fetch bus and IF/ID
// outputs of the fetch stage. The stage connects through the slave modport;
// the hazard unit / instruction memory side uses the master modport.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic             pc_hold_i;
  logic             ifid_hold_i;
  logic             ifid_flush_i;
  logic             pcsrc_i;
  logic [31:0]      branch_target_i;
  logic [31:0]      instr_i;
  logic [31:0]      pc_o;
  logic [31:0]      ifid_pc4_o;
  logic [31:0]      ifid_instr_o;
  logic             ifid_valid_o;
  logic [4:0]       ifid_rs_o;
  logic [4:0]       ifid_rt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output pc_hold_i, ifid_hold_i, ifid_flush_i, pcsrc_i, branch_target_i, instr_i,
    input  pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, ifid_rs_o, ifid_rt_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  pc_hold_i, ifid_hold_i, ifid_flush_i, pcsrc_i, branch_target_i, instr_i,
    output pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, ifid_rs_o, ifid_rt_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: program counter plus IF/ID pipeline register of the five-stage
// MIPS pipeline. Redirects win over PC hold; flush wins over IF/ID hold.
// Optional stall/flush performance counters are built when the macro
// IF_ID_STAGE_PERF_CNT_EN is defined; otherwise both count ports read 0.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  if_id_stage_if.slave  bus
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_RESET   = RESET_PC & ALIGN_MASK;

  logic [31:0] pc_q,         pc_d;
  logic [31:0] ifid_pc4_q,   ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next PC: redirect, then hold, then sequential (wraps modulo 2^32).
  always_comb begin
    pc_d = pc_plus4;
    if (bus.pcsrc_i) begin
      pc_d = bus.branch_target_i & ALIGN_MASK;
    end else if (bus.pc_hold_i) begin
      pc_d = pc_q;
    end
  end

  // Next IF/ID contents: bubble, then hold, then load the fetched word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ifid_instr_d = bus.instr_i;
    ifid_pc4_d   = pc_plus4;
    ifid_valid_d = 1'b1;
    if (bus.ifid_flush_i) begin
      ifid_instr_d = 32'h0000_0000;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else if (bus.ifid_hold_i) begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
    end
  end

  // PC and IF/ID state registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q         <= PC_RESET;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_instr_q <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.ifid_pc4_o   = ifid_pc4_q;
  assign bus.ifid_instr_o = ifid_instr_q;
  assign bus.ifid_valid_o = ifid_valid_q;
  assign bus.ifid_rs_o    = ifid_instr_q[25:21];
  assign bus.ifid_rt_o    = ifid_instr_q[20:16];

`ifdef IF_ID_STAGE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments: stalls count only when no flush overrides the hold.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.ifid_hold_i && !bus.ifid_flush_i && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (bus.ifid_flush_i && flush_cnt_q != CNT_MAX) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // Counter registers, cleared with the rest of the stage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-side pipeline stage of the five-stage MIPS processor: holds the program counter, produces the next PC (sequential or branch-redirected), and registers the fetched instruction into the IF/ID pipeline register. It sits directly upstream of the hazard detection unit. It consumes that unit's hold and flush controls and feeds back the IF/ID `rs`/`rt` fields the unit compares against. An optional pair of performance counters tallies stall and flush cycles.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset; must be word-aligned.
- `CNT_W`, default 16: width of the stall and flush counters.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: asynchronous, active-low reset.
- `pc_hold_i`, input, 1: 1 = keep the PC unchanged this cycle (hazard unit PCWrite).
- `ifid_hold_i`, input, 1: 1 = keep the IF/ID register unchanged (hazard unit IFIDWrite).
- `ifid_flush_i`, input, 1: 1 = load a bubble into IF/ID.
- `pcsrc_i`, input, 1: 1 = redirect the PC to `branch_target_i`.
- `branch_target_i`, input, 32: branch or jump target; bits [1:0] are ignored.
- `instr_i`, input, 32: instruction-memory read data for the current `pc_o`.
- `pc_o`, output, 32: current PC, driven to instruction memory.
- `ifid_pc4_o`, output, 32: registered PC+4 of the instruction held in IF/ID.
- `ifid_instr_o`, output, 32: registered instruction.
- `ifid_valid_o`, output, 1: IF/ID holds a real instruction (0 = bubble).
- `ifid_rs_o`, output, 5: `ifid_instr_o[25:21]`, to the hazard unit.
- `ifid_rt_o`, output, 5: `ifid_instr_o[20:16]`, to the hazard unit.
- `stall_cnt_o`, output, `CNT_W`: count of IF/ID stall cycles (see Configuration).
- `flush_cnt_o`, output, `CNT_W`: count of IF/ID flush cycles (see Configuration).

## Operation
- **PC register**, in priority order:
  - `pcsrc_i` = 1 → PC ← {`branch_target_i[31:2]`, 2'b00}. A redirect is never lost, even when `pc_hold_i` = 1.
  - else `pc_hold_i` = 1 → PC unchanged.
  - else → PC ← PC + 4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. `pc_o[1:0]` is always 0.
- **IF/ID register**, in priority order:
  - `ifid_flush_i` = 1 → instr ← 32'h0000_0000 (nop), pc4 ← 0, valid ← 0.
  - else `ifid_hold_i` = 1 → all fields unchanged.
  - else → instr ← `instr_i`, pc4 ← `pc_o` + 4, valid ← 1.
- Flush beats hold when both are asserted.
- `ifid_rs_o` and `ifid_rt_o` are pure slices of the registered instruction. They read 0 after a flush.
- There is no FSM beyond these registers. The only state is the PC, the IF/ID fields, and the counters.

## Timing
- Reset (`rst_i` low, asynchronous) forces:
  - `pc_o` = `RESET_PC`
  - `ifid_instr_o` = 0, `ifid_pc4_o` = 0, `ifid_valid_o` = 0
  - both counters = 0
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Release is sampled at the next rising edge. The first edge with `rst_i` high loads the instruction at `RESET_PC` into IF/ID.
- Latency: the instruction at PC *n* appears on `ifid_instr_o` one cycle after `pc_o` = *n*, assuming no hold or flush.
- Redirect: on the edge where `pcsrc_i` = 1, `pc_o` becomes the target and IF/ID loads the bubble in the same edge. The target instruction reaches IF/ID one edge later.
- Stall: while both holds are 1, `pc_o` and IF/ID are frozen. The instruction fetched at the frozen PC is re-sampled when the hold drops.
- All inputs are sampled only at the rising edge. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `IF_ID_STAGE_PERF_CNT_EN`.
- **Defined:**
  - `stall_cnt_o` increments on every edge with `ifid_hold_i` = 1 and `ifid_flush_i` = 0.
  - `flush_cnt_o` increments on every edge with `ifid_flush_i` = 1.
  - Both counters saturate at all-ones; they do not wrap.
- **Undefined:** no counter registers are built. Both ports stay present and are tied to 0.

## Test plan
- Reset with `RESET_PC` = 32'h100, then 3 free-running edges with `instr_i` = 32'h8C22_0004 → `pc_o` goes 104, 108, 10C; `ifid_pc4_o` = 32'h10C after the 3rd edge; `ifid_rs_o` = 1, `ifid_rt_o` = 2, `ifid_valid_o` = 1.
- Assert both holds for 2 edges with `pc_o` = 32'h20 → `pc_o` stays 32'h20 and IF/ID is unchanged. With the macro defined, `stall_cnt_o` = 2.
- Apply `pcsrc_i` = 1, flush = 1, `branch_target_i` = 32'h0000_0043 → `pc_o` = 32'h40, `ifid_valid_o` = 0, `ifid_instr_o` = 0. With the macro defined, `flush_cnt_o` increments by 1.
- Apply `pcsrc_i` = 1 together with `pc_hold_i` = 1 and `ifid_hold_i` = 1, plus flush = 1 → the PC still redirects and IF/ID is still bubbled.
- Start from `pc_o` = 32'hFFFF_FFFC and clock 1 free-running edge → `pc_o` = 0 and `ifid_pc4_o` = 0.
- Drop `rst_i` between clock edges mid-run → all outputs return to reset values immediately. With the macro defined, force counter saturation at `CNT_W` = 2 → the count holds at 3.
